// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Conditions the DE2-115 push buttons (active-low, bouncy) for the counter /
//   7-segment path. Each key is synchronised, debounced, and turned into
//   one-cycle press / release / auto-repeat pulses plus a clean pressed level.
// Ports
//   clk           system clock
//   rst_n         synchronous reset, active-low
//   key_n         raw asynchronous buttons, 0 = pressed
//   key_level     debounced pressed level, 1 = pressed
//   press_pulse   1-cycle pulse on accepted press
//   release_pulse 1-cycle pulse on accepted release
//   repeat_pulse  1-cycle pulse per auto-repeat tick while held

// Single key channel: 2-flop synchroniser, debounce FSM, repeat timer.
module key_event_chan #(
   parameter int   DEBOUNCE_CYCLES = 1_000_000,
   parameter int   REPEAT_DELAY    = 25_000_000,
   parameter int   REPEAT_PERIOD   = 5_000_000,
   parameter bit   REPEAT_EN       = 1'b0,
   parameter int   CW              = 25
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse
);

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

   state_t        state_q, state_d;
   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic          rpt_phase_q, rpt_phase_d;   // 0: waiting first delay, 1: periodic
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          repeat_q, repeat_d;
   logic          s;
   logic [CW-1:0] rpt_tgt;

   // Synchroniser holds raw key_n polarity, so reset value 1 means released.
   assign s       = ~sync_q[1];
   assign sync_d  = {sync_q[0], key_n};
   assign rpt_tgt = rpt_phase_q ? PER_LAST : DLY_LAST;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rpt_cnt_d   = rpt_cnt_q;
      rpt_phase_d = rpt_phase_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      repeat_d    = 1'b0;

      // Repeat timer runs while held (including the release debounce window);
      // the release branch below overrides it so release wins.
      if (REPEAT_EN && (state_q == HELD || state_q == RELEASE_WAIT)) begin
         if (rpt_cnt_q == rpt_tgt) begin
            repeat_d    = 1'b1;
            rpt_cnt_d   = '0;
            rpt_phase_d = 1'b1;
         end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (s) begin
               state_d = PRESS_WAIT;
               cnt_d   = CW'(1);
            end
         end
         PRESS_WAIT: begin
            if (!s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d     = HELD;
               cnt_d       = '0;
               level_d     = 1'b1;
               press_d     = 1'b1;
               rpt_cnt_d   = '0;
               rpt_phase_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD: begin
            if (!s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CW'(1);
            end
         end
         RELEASE_WAIT: begin
            if (s) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d     = IDLE;
               cnt_d       = '0;
               level_d     = 1'b0;
               release_d   = 1'b1;
               repeat_d    = 1'b0;
               rpt_cnt_d   = '0;
               rpt_phase_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sync_q      <= 2'b11;
         cnt_q       <= '0;
         rpt_cnt_q   <= '0;
         rpt_phase_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         repeat_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_phase_q <= rpt_phase_d;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         repeat_q    <= repeat_d;
      end
   end

   assign key_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign repeat_pulse  = repeat_q;

endmodule

module key_event_decoder #(
   parameter int                  NUM_KEYS        = 4,
   parameter int                  DEBOUNCE_CYCLES = 1_000_000,
   parameter int                  REPEAT_DELAY    = 25_000_000,
   parameter int                  REPEAT_PERIOD   = 5_000_000,
   parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = 4'b0110
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse,
   output logic [NUM_KEYS-1:0] repeat_pulse
);

   localparam int MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_C  = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
   localparam int CW     = $clog2(MAX_C + 1);

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_event_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .REPEAT_EN       (REPEAT_MASK[k]),
         .CW              (CW)
      ) u_chan (
         .clk           (clk),
         .rst_n         (rst_n),
         .key_n         (key_n[k]),
         .key_level     (key_level[k]),
         .press_pulse   (press_pulse[k]),
         .release_pulse (release_pulse[k]),
         .repeat_pulse  (repeat_pulse[k])
      );
   end

endmodule
